// File: rtl/vid_in_axi4s_stream_ctrl.sv
// Native-video FIFO read sequencer onto an AXI4-Stream master: frame-aligned start, overflow drop-to-SOF.
// Define VID_IN_STREAM_CTRL_STATS_EN to build the per-line LINE_LEN / LINE_CNT statistics counters.
module vid_in_axi4s_stream_ctrl #(
    parameter int C_NATIVE_DATA_WIDTH = 24,
    parameter int C_FRAME_CNT_WIDTH   = 16
) (
    input  logic                           VID_IN_CLK,
    input  logic                           VID_RESET,
    input  logic                           ENABLE,
    input  logic [C_NATIVE_DATA_WIDTH+2:0] FIFO_RD_DATA,
    input  logic                           FIFO_EMPTY,
    output logic                           FIFO_RD_EN,
    input  logic                           FIFO_WR_EN,
    input  logic                           FIFO_FULL,
    output logic [C_NATIVE_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                           M_AXIS_TVALID,
    input  logic                           M_AXIS_TREADY,
    output logic                           M_AXIS_TUSER,
    output logic                           M_AXIS_TLAST,
    output logic                           M_AXIS_FIELD_ID,
    output logic                           OVERFLOW,
    input  logic                           OVERFLOW_CLR,
    output logic [C_FRAME_CNT_WIDTH-1:0]   FRAME_CNT,
    output logic [1:0]                     STATE,
    output logic [15:0]                    LINE_LEN,
    output logic [15:0]                    LINE_CNT
);
    localparam int W = C_NATIVE_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_RUN      = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic                         tvalid_q, tvalid_d;
    logic [W-1:0]                 tdata_q;
    logic                         tuser_q, tlast_q, fid_q;
    logic [C_FRAME_CNT_WIDTH-1:0] frame_cnt_q;
    logic                         overflow_q;

    logic head_sof, ovf_evt, can_load, stop_req, load, rd_en, accept;

    assign head_sof = FIFO_RD_DATA[W+1];
    assign ovf_evt  = FIFO_WR_EN & FIFO_FULL;
    assign can_load = !FIFO_EMPTY && (!tvalid_q || M_AXIS_TREADY);
    // A stop only takes effect on a frame boundary: the SOF head stays in the FIFO.
    assign stop_req = !FIFO_EMPTY && head_sof && !ENABLE;
    assign accept   = tvalid_q & M_AXIS_TREADY;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                rd_en = !FIFO_EMPTY;
                if (ENABLE) state_d = S_WAIT_SOF;
            end
            S_WAIT_SOF, S_DROP: begin
                rd_en = !FIFO_EMPTY && !head_sof;
                if (!ENABLE)                     state_d = S_IDLE;
                else if (ovf_evt)                state_d = S_DROP;
                else if (!FIFO_EMPTY && head_sof) state_d = S_RUN;
            end
            S_RUN: begin
                load  = can_load && !stop_req;
                rd_en = load;
                if (ovf_evt)       state_d = S_DROP;
                else if (stop_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tvalid_d = tvalid_q;
        if (load)               tvalid_d = 1'b1;
        else if (M_AXIS_TREADY) tvalid_d = 1'b0;
    end

    always_ff @(posedge VID_IN_CLK or posedge VID_RESET) begin
        if (VID_RESET) begin
            state_q     <= S_IDLE;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
            fid_q       <= 1'b0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            if (load) begin
                fid_q   <= FIFO_RD_DATA[W+2];
                tuser_q <= FIFO_RD_DATA[W+1];
                tlast_q <= FIFO_RD_DATA[W];
                tdata_q <= FIFO_RD_DATA[W-1:0];
            end
            if (accept && tuser_q) frame_cnt_q <= frame_cnt_q + C_FRAME_CNT_WIDTH'(1);
            // A new overflow outranks a clear arriving in the same cycle.
            overflow_q <= ovf_evt | (overflow_q & ~OVERFLOW_CLR);
        end
    end

`ifdef VID_IN_STREAM_CTRL_STATS_EN
    logic [15:0] beat_cnt_q, line_len_q, line_cnt_q;
    logic [15:0] beat_inc, line_base;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign beat_inc  = sat_inc(beat_cnt_q);
    assign line_base = tuser_q ? 16'd0 : line_cnt_q;

    always_ff @(posedge VID_IN_CLK or posedge VID_RESET) begin
        if (VID_RESET) begin
            beat_cnt_q <= '0;
            line_len_q <= '0;
            line_cnt_q <= '0;
        end else if (accept) begin
            if (tlast_q) begin
                line_len_q <= beat_inc;
                beat_cnt_q <= '0;
                line_cnt_q <= sat_inc(line_base);
            end else begin
                beat_cnt_q <= beat_inc;
                line_cnt_q <= line_base;
            end
        end
    end

    assign LINE_LEN = line_len_q;
    assign LINE_CNT = line_cnt_q;
`else
    assign LINE_LEN = '0;
    assign LINE_CNT = '0;
`endif

    assign FIFO_RD_EN      = rd_en;
    assign M_AXIS_TDATA    = tdata_q;
    assign M_AXIS_TVALID   = tvalid_q;
    assign M_AXIS_TUSER    = tuser_q;
    assign M_AXIS_TLAST    = tlast_q;
    assign M_AXIS_FIELD_ID = fid_q;
    assign OVERFLOW        = overflow_q;
    assign FRAME_CNT       = frame_cnt_q;
    assign STATE           = state_q;

endmodule
